// File: rtl/instr_reg_decode_pkg.sv
// Shared constants for the multicycle MIPS instruction register: extension-unit opcodes,
// instruction opcodes and fetch FSM state encodings.
package instr_reg_decode_pkg;

  localparam logic [1:0] EXTOP_UNSIGNED = 2'b00;
  localparam logic [1:0] EXTOP_SIGNED   = 2'b01;
  localparam logic [1:0] EXTOP_INST     = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_reg_decode_ext_op_decode.sv
// Opcode to extension-unit control decode; also flags opcodes outside the supported set.
module instr_reg_decode_ext_op_decode
  import instr_reg_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [1:0] ext_op,
  output logic       illegal
);

  always_comb begin
    ext_op  = EXTOP_UNSIGNED;
    illegal = 1'b0;
    unique case (opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_BNE:
        ext_op = EXTOP_SIGNED;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        ext_op = EXTOP_UNSIGNED;
      OP_RTYPE, OP_J, OP_JAL:
        ext_op = EXTOP_INST;
      default: begin
        ext_op  = EXTOP_UNSIGNED;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_reg_decode.sv
// Instruction register with req/ack fetch FSM and field split for the multicycle MIPS datapath.
// All outputs come from flops or from IR alone, so they are stable across the following negedge.
module instr_reg_decode
  import instr_reg_decode_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        busy,
  output logic        ir_valid,
  output logic        fetch_err,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic [1:0]  ext_op,
  output logic        illegal
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ir_valid_q, ir_valid_d;
  logic             fetch_err_q, fetch_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      ir_q        <= RESET_INSTR;
      cnt_q       <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    ir_valid_d  = ir_valid_q;
    fetch_err_d = 1'b0;
    if (flush) begin
      // Flush overrides any same-cycle fetch_start or ack; IR keeps its old word.
      state_d    = StIdle;
      ir_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (fetch_start) begin
            state_d    = StReq;
            addr_d     = pc;
            cnt_d      = '0;
            ir_valid_d = 1'b0;
          end
        end
        StReq: begin
          // An ack on the final count still completes the fetch.
          if (imem_ack) begin
            ir_d       = imem_rdata;
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end else if (cnt_q == CNT_LAST) begin
            fetch_err_d = 1'b1;
            ir_valid_d  = 1'b0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StReq);
  assign busy      = (state_q == StReq);
  assign imem_addr = addr_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;

  assign instr  = ir_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];
  assign jaddr  = ir_q[25:0];

  instr_reg_decode_ext_op_decode u_ext_op_decode (
    .opcode  (ir_q[31:26]),
    .ext_op  (ext_op),
    .illegal (illegal)
  );

endmodule

// File: tb/tb_instr_reg_decode.sv
// Directed bench for instr_reg_decode: expected IR contents are queued when a fetch is driven
// and checked against the decoded outputs once ir_valid rises.
module tb_instr_reg_decode;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        busy, ir_valid, fetch_err, illegal;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [1:0]  ext_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  ext;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  instr_reg_decode #(
    .TIMEOUT     (TO),
    .RESET_INSTR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_start (fetch_start),
    .flush       (flush),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .busy        (busy),
    .ir_valid    (ir_valid),
    .fetch_err   (fetch_err),
    .instr       (instr),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16),
    .jaddr       (jaddr),
    .ext_op      (ext_op),
    .illegal     (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the ack has been sampled.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int ack_delay,
                       input logic [1:0] ext, input logic ill, input bit extra_start);
    exp_t e;
    int   n;
    sb.push_back('{word: word, ext: ext, ill: ill});
    fetch_start = 1'b1;
    pc          = addr;
    @(negedge clk);
    fetch_start = extra_start;
    pc          = addr ^ 32'h0000_0F00;
    chk("req_on", imem_req, 1);
    chk("busy_on", busy, 1);
    chk("valid_drop", ir_valid, 0);
    chk("addr_latch", imem_addr, addr);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      fetch_start = 1'b0;
      chk("addr_hold", imem_addr, addr);
      chk("req_hold", imem_req, 1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    fetch_start = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    n = 0;
    while (ir_valid !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("ir_valid_set", ir_valid, 1);
    chk("no_fetch_err", fetch_err, 0);
    chk("req_off", imem_req, 0);
    chk("busy_off", busy, 0);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr", instr, e.word);
      chk("opcode", opcode, e.word[31:26]);
      chk("rs", rs, e.word[25:21]);
      chk("rt", rt, e.word[20:16]);
      chk("rd", rd, e.word[15:11]);
      chk("shamt", shamt, e.word[10:6]);
      chk("funct", funct, e.word[5:0]);
      chk("imm16", imm16, e.word[15:0]);
      chk("jaddr", jaddr, e.word[25:0]);
      chk("ext_op", ext_op, e.ext);
      chk("illegal", illegal, e.ill);
    end
  endtask

  initial begin
    logic [31:0] last_word;
    int          k;

    // Reset
    pc = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_ext_op", ext_op, 2'b10);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", imem_req, 0);
    chk("idle_valid", ir_valid, 0);

    // addi with ack after three wait cycles
    fetch(32'h0000_0040, 32'h2108_FFFF, 3, 2'b01, 1'b0, 1'b0);
    chk("addi_imm16", imm16, 16'hFFFF);
    chk("addi_rs", rs, 8);
    chk("addi_rt", rt, 8);

    // ori from HOLD with minimum latency
    fetch(32'h0000_0044, 32'h3508_8000, 0, 2'b00, 1'b0, 1'b0);
    chk("ori_imm16", imm16, 16'h8000);

    // j, ack arriving on the last cycle before timeout
    fetch(32'h0000_0048, 32'h0800_0010, TO - 1, 2'b10, 1'b0, 1'b0);
    chk("j_jaddr", jaddr, 26'h10);
    last_word = 32'h0800_0010;

    // Timeout: no ack
    @(negedge clk);
    fetch_start = 1'b1;
    pc          = 32'h0000_0100;
    @(negedge clk);
    fetch_start = 1'b0;
    k = 0;
    while (fetch_err !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_cycles", k, TO);
    chk("timeout_valid", ir_valid, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_req", imem_req, 0);
    chk("timeout_instr", instr, last_word);
    @(negedge clk);
    chk("timeout_pulse", fetch_err, 0);
    chk("timeout_idle", imem_req, 0);

    // Flush one cycle into REQ with a concurrent ack
    fetch_start = 1'b1;
    pc          = 32'h0000_0200;
    @(negedge clk);
    fetch_start = 1'b0;
    flush       = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h2000_1234;
    @(negedge clk);
    flush    = 1'b0;
    imem_ack = 1'b0;
    chk("flush_instr", instr, last_word);
    chk("flush_valid", ir_valid, 0);
    chk("flush_req", imem_req, 0);
    chk("flush_busy", busy, 0);
    @(negedge clk);
    chk("flush_stays_idle", imem_req, 0);

    // Illegal opcode with a second fetch_start during REQ
    fetch(32'h0000_0300, 32'hFC21_1234, 2, 2'b00, 1'b1, 1'b1);
    last_word = 32'hFC21_1234;

    // Ack while in HOLD is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'h3C01_5555;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("hold_ack_ignored", instr, last_word);
    chk("hold_valid", ir_valid, 1);

    // Flush from HOLD drops ir_valid but keeps IR
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("hold_flush_valid", ir_valid, 0);
    chk("hold_flush_instr", instr, last_word);

    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_reg_decode.md
Name: instr_reg_decode

Overview:
- Instruction register and field decoder for the multicycle MIPS datapath.
- Fetches one 32-bit word from instruction memory over a req/ack handshake and holds it in IR until the next fetch.
- Splits IR into its fields and derives the 2-bit extension opcode that drives the sign-extension unit directly downstream.
- All outputs are registered or decoded from IR only, so they are stable from the posedge through the following negedge, where the extension unit samples.

Parameters:
- TIMEOUT, 16, max cycles to wait for imem_ack before aborting the fetch (must be ≥ 2).
- RESET_INSTR, 32'h0000_0000, IR value after reset (decodes as sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  one-cycle pulse from control FSM requesting a fetch.
- flush  in  1  abort any fetch in progress, invalidate IR.
- pc  in  32  fetch address; sampled on the accepted fetch_start.
- imem_req  out  1  memory request.
- imem_addr  out  32  latched fetch address.
- imem_ack  in  1  memory data valid this cycle.
- imem_rdata  in  32  instruction word.
- busy  out  1  fetch in progress.
- ir_valid  out  1  IR holds a freshly fetched, unflushed instruction.
- fetch_err  out  1  one-cycle pulse on timeout.
- instr  out  32  IR contents.
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- shamt  out  5  IR[10:6].
- funct  out  6  IR[5:0].
- imm16  out  16  IR[15:0], feeds the extension unit's 16-bit input.
- jaddr  out  26  IR[25:0].
- ext_op  out  2  extension opcode, encoded with the shared EXTOP constants.
- illegal  out  1  opcode not in the supported set.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, IR=RESET_INSTR, imem_req=0, imem_addr=0, busy=0, ir_valid=0, fetch_err=0, timeout count=0.
  - Decoded outputs follow RESET_INSTR, giving ext_op=EXTOP_INST and illegal=0.
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - fetch_start=1 and flush=0 → latch imem_addr=pc, clear count, imem_req=1, busy=1, ir_valid=0 next cycle, go to REQ.
- REQ:
  - imem_req held high, imem_addr held stable, count increments each cycle.
  - imem_ack=1 → IR<=imem_rdata, imem_req=0, busy=0, ir_valid=1, go to HOLD. Fields are visible the cycle after ack, so minimum fetch latency is 2 cycles from fetch_start.
  - fetch_start during REQ is ignored.
  - count reaches TIMEOUT-1 with no ack → fetch_err=1 for one cycle, imem_req=0, busy=0, IR unchanged, ir_valid=0, go to IDLE.
  - imem_ack in the same cycle the timeout fires: the ack wins and the fetch completes normally.
- HOLD:
  - IR and all fields are frozen.
  - fetch_start → same action as in IDLE, including ir_valid dropping the next cycle.
- flush (any state, highest priority after reset):
  - next cycle state=IDLE, imem_req=0, busy=0, ir_valid=0, IR unchanged.
  - A concurrent fetch_start or imem_ack is ignored.
- ext_op decode is combinational from IR opcode:
  - EXTOP_SIGNED for 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 100011 lw, 101011 sw, 000100 beq, 000101 bne.
  - EXTOP_UNSIGNED for 001100 andi, 001101 ori, 001110 xori, 001111 lui.
  - EXTOP_INST for 000000 R-type, 000010 j, 000011 jal.
  - Any other opcode → EXTOP_UNSIGNED with illegal=1.
- imem_rdata is only ever captured on imem_ack in REQ; acks in other states are ignored.

Decomposition:
- Shared define file holds:
  - EXTOP_UNSIGNED=2'b00, EXTOP_SIGNED=2'b01, EXTOP_INST=2'b10 (the existing constants).
  - Opcode constants (OP_RTYPE, OP_ADDI, OP_LW, ...).
  - Fetch FSM state encodings.
- Natural sub-module: ext_op_decode, purely combinational, opcode in → ext_op and illegal out. It is reused by the control FSM.

Test Plan:
- Reset with no other stimulus → instr=0, ir_valid=0, busy=0, imem_req=0, ext_op=2'b10, illegal=0.
- fetch_start with pc=32'h0000_0040, ack after 3 cycles with rdata=32'h2108_FFFF (addi) → imem_addr=0x40 throughout REQ; then ir_valid=1, imm16=16'hFFFF, rs=8, rt=8, ext_op=2'b01.
- Fetch 32'h3508_8000 (ori) → ext_op=2'b00, imm16=16'h8000. Fetch 32'h0800_0010 (j) → ext_op=2'b10, jaddr=26'h10.
- TIMEOUT=16 and ack never arrives → fetch_err pulses once, 16 cycles after REQ entry. IR keeps its prior value, ir_valid=0, state returns to IDLE.
- flush asserted 1 cycle into REQ, imem_ack asserted on the same cycle → IR unchanged, ir_valid=0, imem_req=0 next cycle.
- Opcode 6'b111111 fetched → illegal=1, ext_op=2'b00. A second fetch_start during REQ is ignored and imem_addr stays at the original pc.
